lb_arbiter: RTL and testbench

Two-master arbiter for the local bus (lb_*) that feeds a generated register map. It shares one local-bus slave between master 0 (typically the apb2lb bridge) and master 1 (an internal sequencer or debug port). The arbiter uses round-robin grant and holds each grant for exactly one complete write or read transaction. A watchdog terminates any transaction the slave never completes and signals an error.

---
 rtl/lb_arbiter_pkg.sv | 17 +
 rtl/lb_arb_wdt.sv | 42 ++++
 rtl/lb_arbiter.sv | 145 ++++++++++++++
 tb/tb_lb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_arbiter_pkg.sv
// Shared types for the two-master local-bus arbiter.
// Owner index, grant state and operation encodings live here.
package lb_arbiter_pkg;

  typedef enum logic {IDLE, GNT} state_t;
  typedef enum logic {OP_WR, OP_RD} op_t;
  typedef logic owner_t;

  localparam owner_t M0 = 1'b0;
  localparam owner_t M1 = 1'b1;

  // Watchdog counter must hold 0..TIMEOUT; keep at least one bit.
  function automatic int wdt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lb_arb_wdt.sv
// Transaction watchdog: counts cycles of an outstanding grant and flags
// expiry in the TIMEOUT-1 count cycle. TIMEOUT = 0 disables it.
module lb_arb_wdt
  import lb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = wdt_width(TIMEOUT);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Saturate at LAST; the arbiter leaves GNT in that cycle anyway.
      always_comb begin
        cnt_d = cnt_q;
        if (clr)
          cnt_d = '0;
        else if (en && (cnt_q != LAST))
          cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign expire = en & (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/lb_arbiter.sv
// Two-master round-robin arbiter for one local-bus slave. Each grant covers
// exactly one write or read; a watchdog terminates transactions the slave drops.
module lb_arbiter
  import lb_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                STRB_W   = DATA_W / 8,
  parameter int                TIMEOUT  = 256,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADDEAD)
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic [ADDR_W-1:0] m0_waddr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_raddr,
  input  logic              m0_ren,
  output logic              m0_wready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  // master 1
  input  logic [ADDR_W-1:0] m1_waddr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_raddr,
  input  logic              m1_ren,
  output logic              m1_wready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  // slave
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t ptr_q, ptr_d;
  op_t    op_q, op_d;

  logic              req0, req1, gnt, is_wr, own1;
  logic              done, expire, wr_cpl, rd_cpl;
  logic              sel_wen, sel_ren;
  logic [ADDR_W-1:0] sel_waddr, sel_raddr;
  logic [DATA_W-1:0] sel_wdata, cpl_rdata;
  logic [STRB_W-1:0] sel_wstrb;
  owner_t            win;

  assign req0  = m0_wen | m0_ren;
  assign req1  = m1_wen | m1_ren;
  assign gnt   = (state_q == GNT);
  assign is_wr = (op_q == OP_WR);
  assign own1  = (owner_q == M1);

  // Owner's request view
  assign sel_waddr = own1 ? m1_waddr : m0_waddr;
  assign sel_wdata = own1 ? m1_wdata : m0_wdata;
  assign sel_wstrb = own1 ? m1_wstrb : m0_wstrb;
  assign sel_wen   = own1 ? m1_wen   : m0_wen;
  assign sel_raddr = own1 ? m1_raddr : m0_raddr;
  assign sel_ren   = own1 ? m1_ren   : m0_ren;

  assign lb_waddr = gnt ? sel_waddr : '0;
  assign lb_wdata = gnt ? sel_wdata : '0;
  assign lb_wstrb = gnt ? sel_wstrb : '0;
  assign lb_raddr = gnt ? sel_raddr : '0;
  assign lb_wen   = gnt &  is_wr & sel_wen;
  assign lb_ren   = gnt & ~is_wr & sel_ren;

  // A real completion in the expiry cycle masks the watchdog.
  assign done = gnt & (is_wr ? lb_wready : lb_rvalid);

  lb_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (~gnt),
    .en     (gnt & ~done),
    .expire (expire)
  );

  assign wr_cpl    = gnt &  is_wr & (lb_wready | expire);
  assign rd_cpl    = gnt & ~is_wr & (lb_rvalid | expire);
  assign cpl_rdata = lb_rvalid ? lb_rdata : ERR_DATA;

  assign m0_wready = wr_cpl & ~own1;
  assign m0_rvalid = rd_cpl & ~own1;
  assign m0_rdata  = (rd_cpl & ~own1) ? cpl_rdata : '0;
  assign m0_err    = expire & ~own1;
  assign m1_wready = wr_cpl &  own1;
  assign m1_rvalid = rd_cpl &  own1;
  assign m1_rdata  = (rd_cpl &  own1) ? cpl_rdata : '0;
  assign m1_err    = expire &  own1;

  // The pointer only advances when it actually settles a contended grant,
  // so a lone requester never steals the other master's next turn.
  assign win = (req0 & req1) ? ptr_q : owner_t'(req1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = GNT;
          owner_d = win;
          op_d    = ((win == M1) ? m1_wen : m0_wen) ? OP_WR : OP_RD;
          if (req0 & req1) ptr_d = ~ptr_q;
        end
      end
      GNT: begin
        if (done | expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= M0;
      ptr_q   <= M0;
      op_q    <= OP_WR;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_lb_arbiter.sv
// Randomized + directed bench for lb_arbiter: a slave model with memory,
// a reference memory predicting master responses, and a scoreboard monitor.
module tb_lb_arbiter;
  localparam int AW = 16, DW = 32, SW = 4, TO = 8;
  localparam logic [DW-1:0] ERRD = 32'hDEADDEAD;

  typedef struct { bit rd; logic [DW-1:0] data; bit err; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] waddr[2], raddr[2];
  logic [DW-1:0] wdata[2];
  logic [SW-1:0] wstrb[2];
  logic          wen[2], ren[2];
  logic          m0_wready, m0_rvalid, m0_err, m1_wready, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] lb_waddr, lb_raddr;
  logic [DW-1:0] lb_wdata, lb_rdata;
  logic [SW-1:0] lb_wstrb;
  logic          lb_wen, lb_ren, lb_wready, lb_rvalid;

  lb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .m0_waddr(waddr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wen(wen[0]),
    .m0_raddr(raddr[0]), .m0_ren(ren[0]), .m0_wready(m0_wready), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_waddr(waddr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wen(wen[1]),
    .m1_raddr(raddr[1]), .m1_ren(ren[1]), .m1_wready(m1_wready), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
    .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren),
    .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
  );

  int   checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  int   order[$];
  logic [DW-1:0] rmem[logic [AW-1:0]];
  logic [DW-1:0] smem[logic [AW-1:0]];
  bit   mute = 0, inject = 0, slv_rand = 0;
  int   slv_lat = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rget(input logic [AW-1:0] a);
    return rmem.exists(a) ? rmem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] sget(input logic [AW-1:0] a);
    return smem.exists(a) ? smem[a] : '0;
  endfunction

  task automatic push(input int m, input exp_t e);
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Caller sits at posedge+#1. Predicts responses, drives the request, holds it
  // until completion, drops it the cycle after. ncyc counts negedges waited.
  task automatic txn(input int m, input bit w, input bit r, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [SW-1:0] s, input bit to,
                     output int ncyc);
    exp_t e;
    bit dw, dr;
    if (w) begin
      e.rd = 0; e.data = '0; e.err = to; push(m, e);
      if (!to) rmem[a] = merge(rget(a), d, s);
    end
    if (r) begin
      e.rd = 1; e.data = to ? ERRD : rget(a); e.err = to; push(m, e);
    end
    waddr[m] = a; raddr[m] = a; wdata[m] = d; wstrb[m] = s;
    wen[m] = w; ren[m] = r; ncyc = 0;
    while (wen[m] || ren[m]) begin
      @(negedge clk); ncyc++;
      dw = (m == 0) ? m0_wready : m1_wready;
      dr = (m == 0) ? m0_rvalid : m1_rvalid;
      @(posedge clk); #1;
      if (dw) wen[m] = 0;
      if (dr) ren[m] = 0;
      if (ncyc > 64 && (wen[m] || ren[m])) begin
        check($sformatf("m%0d_txn_budget", m), 64'(ncyc), 64'(0));
        wen[m] = 0; ren[m] = 0;
      end
    end
  endtask

  task automatic mon_one(input int m, input logic wr, input logic rv,
                         input logic [DW-1:0] rd, input logic er);
    exp_t e;
    if (wr || rv) begin
      if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
        check($sformatf("m%0d_unexpected_cpl", m), {62'd0, wr, rv}, 64'd0);
      end else begin
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("m%0d_kind", m), {62'd0, wr, rv}, {62'd0, ~e.rd, e.rd});
        if (e.rd) check($sformatf("m%0d_rdata", m), 64'(rd), 64'(e.data));
        check($sformatf("m%0d_err", m), 64'(er), 64'(e.err));
        order.push_back(m);
      end
    end else if (er) begin
      check($sformatf("m%0d_err_without_cpl", m), 64'(er), 64'd0);
    end
  endtask

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    mon_one(0, m0_wready, m0_rvalid, m0_rdata, m0_err);
    mon_one(1, m1_wready, m1_rvalid, m1_rdata, m1_err);
  end

  // Slave model: responds after a fixed or random latency unless muted.
  initial begin
    bit busy = 0;
    int wcnt = 0, cur = 0;
    lb_wready = 0; lb_rvalid = 0; lb_rdata = '0;
    forever begin
      @(posedge clk); #2;
      lb_wready = 0; lb_rvalid = 0;
      if (inject) begin
        lb_rvalid = 1; lb_rdata = 32'h13572468; inject = 0; busy = 0;
      end else if (!mute && !rst && (lb_wen || lb_ren)) begin
        if (!busy) begin
          busy = 1; wcnt = 0;
          cur = slv_rand ? int'($urandom_range(0, 3)) : slv_lat;
        end
        if (wcnt == cur) begin
          if (lb_wen) begin
            smem[lb_waddr] = merge(sget(lb_waddr), lb_wdata, lb_wstrb); lb_wready = 1;
          end else begin
            lb_rdata = sget(lb_raddr); lb_rvalid = 1;
          end
          busy = 0;
        end else wcnt++;
      end else busy = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [63:0] all_outs();
    return {44'd0, lb_wen, lb_ren, m0_wready, m0_rvalid, m0_err, m1_wready, m1_rvalid, m1_err,
            12'(|{m0_rdata, m1_rdata, lb_waddr, lb_raddr, lb_wdata, lb_wstrb})};
  endfunction

  task automatic contend(input bit w, input logic [AW-1:0] a, input int first, input string nm);
    int n0, n1;
    order.delete();
    fork
      txn(0, w, !w, a, 32'h0badc0de, 4'hf, 0, n0);
      txn(1, w, !w, a, 32'h0badc0de, 4'hf, 0, n1);
    join
    check({nm, "_first"}, 64'(order.size() > 0 ? order[0] : 9), 64'(first));
    check({nm, "_second"}, 64'(order.size() > 1 ? order[1] : 9), 64'(1 - first));
  endtask

  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      waddr[m] = '0; raddr[m] = '0; wdata[m] = '0; wstrb[m] = '0; wen[m] = 0; ren[m] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // Single write with arbitration latency, then read back through m1
    fork
      txn(0, 1, 0, 16'h0, 32'hdeadbeef, 4'b1111, 0, n);
      begin
        @(negedge clk); check("lb_wen_req_cycle", 64'(lb_wen), 64'd0);
        @(negedge clk); check("lb_wen_next_cycle", 64'(lb_wen), 64'd1);
        check("lb_waddr", 64'(lb_waddr), 64'h0);
        check("lb_wdata", 64'(lb_wdata), 64'hdeadbeef);
      end
    join
    check("wr_latency", 64'(n), 64'd3);
    txn(1, 0, 1, 16'h0, '0, '0, 0, n);

    // Contention: m0 first after reset, then m1 on the repeat
    txn(0, 1, 0, 16'h4, 32'h0badc0de, 4'hf, 0, n);
    contend(0, 16'h4, 0, "contend1");
    contend(0, 16'h4, 1, "contend2");

    // Write+read together on m1: write served first, read sees merge
    txn(1, 1, 1, 16'h0, 32'h66778899, 4'b0110, 0, n);

    // Read timeout and ignored late response
    mute = 1;
    txn(0, 0, 1, 16'h8, '0, '0, 1, n);
    check("rd_timeout_latency", 64'(n), 64'(TO + 1));
    repeat (2) begin @(posedge clk); #1; end
    inject = 1;
    @(posedge clk); @(negedge clk);
    check("late_rvalid_ignored", {60'd0, m0_rvalid, m1_rvalid, m0_err, m1_err}, 64'd0);
    @(posedge clk); #1;
    txn(1, 1, 0, 16'h40, 32'h11111111, 4'hf, 1, n);
    check("wr_timeout_latency", 64'(n), 64'(TO + 1));

    // Completion exactly in the last watchdog cycle wins
    mute = 0; slv_lat = TO - 1;
    txn(0, 1, 0, 16'hc, 32'hcafef00d, 4'hf, 0, n);
    check("edge_cpl_latency", 64'(n), 64'(TO + 1));
    slv_lat = 1;
    txn(0, 0, 1, 16'hc, '0, '0, 0, n);

    // Reset mid-read: leave pointer at m1, then reset must restore m0 priority
    contend(1, 16'h10, 0, "contend3");
    mute = 1;
    raddr[0] = 16'h4; ren[0] = 1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_lb_ren", 64'(lb_ren), 64'd1);
    #2 rst = 1;
    #1 check("rst_outputs", all_outs(), 64'd0);
    ren[0] = 0;
    @(posedge clk); #1; rst = 0; mute = 0;
    @(posedge clk); #1;
    contend(0, 16'h4, 0, "post_rst");

    // Randomized traffic, disjoint address windows per master
    slv_rand = 1;
    fork
      for (int i = 0; i < 30; i++) begin
        int k0, g0, c0;
        g0 = $urandom_range(0, 3);
        repeat (g0) begin @(posedge clk); #1; end
        k0 = $urandom_range(0, 2);
        txn(0, k0 != 1, k0 != 0, 16'h100 + 16'(4 * $urandom_range(0, 7)), $urandom,
            4'($urandom_range(1, 15)), 0, c0);
      end
      for (int j = 0; j < 30; j++) begin
        int k1, g1, c1;
        g1 = $urandom_range(0, 3);
        repeat (g1) begin @(posedge clk); #1; end
        k1 = $urandom_range(0, 2);
        txn(1, k1 != 1, k1 != 0, 16'h200 + 16'(4 * $urandom_range(0, 7)), $urandom,
            4'($urandom_range(1, 15)), 0, c1);
      end
    join

    repeat (3) @(posedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
